l2_axi_line_engine: RTL and testbench

L2_AXI_LINE_ENGINE -- requirements
Module: l2_axi_line_engine

---
 rtl/l2_axi_line_engine.sv | 141 ++++++++++++++
 tb/tb_l2_axi_line_engine.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_axi_line_engine.sv
// Moves one 512-bit cache line between the L2 and an AXI slave: a fill is a single
// AR burst assembled beat by beat, a write-back is a single AW/W burst with B handshake.
module l2_axi_line_engine #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BEATS          = 512 / AXI_DATA_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [25:0]               req_line,
  input  logic [511:0]              req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_write,
  output logic [511:0]              rsp_data,
  output logic [31:0]               m_aradr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arprot,
  output logic                      m_arvalid,
  input  logic                      s_arready,
  input  logic [AXI_DATA_WIDTH-1:0] s_rdata,
  input  logic                      s_rvalid,
  output logic                      m_rready,
  output logic [31:0]               m_awadr,
  output logic [7:0]                m_awlen,
  output logic [2:0]                m_awprot,
  output logic                      m_awvalid,
  input  logic                      s_awready,
  output logic [AXI_DATA_WIDTH-1:0] m_wdata,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      m_bready
);

  localparam int              KW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(BEATS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_AR    = 3'd1;
  localparam logic [2:0] S_RDATA = 3'd2;
  localparam logic [2:0] S_AW    = 3'd3;
  localparam logic [2:0] S_WDATA = 3'd4;
  localparam logic [2:0] S_BRESP = 3'd5;
  localparam logic [2:0] S_RSP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          write_q;
  logic [25:0]   line_q;
  logic [511:0]  data_q;
  logic          accept;

  assign accept = req_valid && req_ready;

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = req_write ? S_AW : S_AR;
          k_d     = '0;
        end
      end
      S_AR:    if (s_arready) state_d = S_RDATA;
      S_RDATA: begin
        if (s_rvalid) begin
          k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
          if (k_q == K_LAST) state_d = S_RSP;
        end
      end
      S_AW:    if (s_awready) state_d = S_WDATA;
      S_WDATA: begin
        if (s_wready) begin
          k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
          if (k_q == K_LAST) state_d = S_BRESP;
        end
      end
      S_BRESP: if (s_bvalid) state_d = S_RSP;
      S_RSP:   if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs are flops decoded from the next state, so none of them has a
  // combinational path from an AXI input.
  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      write_q   <= 1'b0;
      line_q    <= '0;
      // NOTE: the line buffer is reset on purpose so rsp_data and m_wdata read 0 after reset.
      data_q    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_wlast   <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (accept) begin
        write_q <= req_write;
        line_q  <= req_line;
        data_q  <= req_data;
      end else if (state_q == S_RDATA && s_rvalid) begin
        data_q[int'(k_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= s_rdata;
      end
      req_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RSP);
      m_arvalid <= (state_d == S_AR);
      m_rready  <= (state_d == S_RDATA);
      m_awvalid <= (state_d == S_AW);
      m_wvalid  <= (state_d == S_WDATA);
      m_wlast   <= (state_d == S_WDATA) && (k_d == K_LAST);
      m_bready  <= (state_d == S_BRESP);
    end
  end

  // A fill overwrites every beat of the buffer, so one buffer serves both directions.
  assign m_aradr   = {line_q, 6'b0};
  assign m_awadr   = {line_q, 6'b0};
  assign m_arlen   = 8'(BEATS - 1);
  assign m_awlen   = 8'(BEATS - 1);
  assign m_arprot  = 3'b000;
  assign m_awprot  = 3'b000;
  assign m_wdata   = data_q[int'(k_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign rsp_write = write_q;
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_l2_axi_line_engine.sv
// Self-checking bench: a behavioural AXI slave plus a line-level model of the expected
// transfers, exercising a 32-bit and a 128-bit instance.
module tb_l2_axi_line_engine;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // 32-bit instance
  logic         req_valid, req_ready, req_write;
  logic [25:0]  req_line;
  logic [511:0] req_data;
  logic         rsp_valid, rsp_ready, rsp_write;
  logic [511:0] rsp_data;
  logic [31:0]  m_aradr, m_awadr;
  logic [7:0]   m_arlen, m_awlen;
  logic [2:0]   m_arprot, m_awprot;
  logic         m_arvalid, s_arready, m_awvalid, s_awready;
  logic [31:0]  s_rdata, m_wdata;
  logic         s_rvalid, m_rready, m_wlast, m_wvalid, s_wready, s_bvalid, m_bready;

  l2_axi_line_engine #(.AXI_DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line(req_line), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .m_aradr(m_aradr), .m_arlen(m_arlen), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rvalid(s_rvalid), .m_rready(m_rready),
    .m_awadr(m_awadr), .m_awlen(m_awlen), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .s_awready(s_awready), .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .m_bready(m_bready)
  );

  // 128-bit instance
  logic         w_req_valid, w_req_ready, w_req_write;
  logic [25:0]  w_req_line;
  logic [511:0] w_req_data;
  logic         w_rsp_valid, w_rsp_ready, w_rsp_write;
  logic [511:0] w_rsp_data;
  logic [31:0]  w_m_aradr, w_m_awadr;
  logic [7:0]   w_m_arlen, w_m_awlen;
  logic [2:0]   w_m_arprot, w_m_awprot;
  logic         w_m_arvalid, w_s_arready, w_m_awvalid, w_s_awready;
  logic [127:0] w_s_rdata, w_m_wdata;
  logic         w_s_rvalid, w_m_rready, w_m_wlast, w_m_wvalid, w_s_wready, w_s_bvalid, w_m_bready;

  l2_axi_line_engine #(.AXI_DATA_WIDTH(128)) dut_wide (
    .clk(clk), .reset_n(reset_n),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
    .req_line(w_req_line), .req_data(w_req_data),
    .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready), .rsp_write(w_rsp_write), .rsp_data(w_rsp_data),
    .m_aradr(w_m_aradr), .m_arlen(w_m_arlen), .m_arprot(w_m_arprot), .m_arvalid(w_m_arvalid),
    .s_arready(w_s_arready), .s_rdata(w_s_rdata), .s_rvalid(w_s_rvalid), .m_rready(w_m_rready),
    .m_awadr(w_m_awadr), .m_awlen(w_m_awlen), .m_awprot(w_m_awprot), .m_awvalid(w_m_awvalid),
    .s_awready(w_s_awready), .m_wdata(w_m_wdata), .m_wlast(w_m_wlast), .m_wvalid(w_m_wvalid),
    .s_wready(w_s_wready), .s_bvalid(w_s_bvalid), .m_bready(w_m_bready)
  );

  // Observations gathered by the slave model during one narrow transaction.
  logic [511:0] o_data;
  logic         o_write, o_ready_after, o_valid_after, o_timeout;
  logic [31:0]  o_addr;
  logic [7:0]   o_len;
  logic [2:0]   o_prot;
  int o_latency, o_arv, o_awv, o_wbeats, o_wdata_err, o_wlast_err;
  int o_rsp_cycles, o_rsp_unstable, o_rr_in_rsp, o_extra;

  // Observations for the wide instance.
  logic [511:0] wo_data;
  logic         wo_write, wo_timeout;
  logic [7:0]   wo_len;
  int wo_latency, wo_beats, wo_err;

  function automatic logic [511:0] rand_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_line = '0; req_data = '0; rsp_ready = 0;
    s_arready = 0; s_awready = 0; s_rvalid = 0; s_rdata = '0; s_wready = 0; s_bvalid = 0;
    w_req_valid = 0; w_req_write = 0; w_req_line = '0; w_req_data = '0; w_rsp_ready = 0;
    w_s_arready = 0; w_s_awready = 0; w_s_rvalid = 0; w_s_rdata = '0; w_s_wready = 0; w_s_bvalid = 0;
  endtask

  // Behavioural slave for the 32-bit instance. For a fill, `data` is the line the
  // slave returns; for a write-back it is the line the master must send. wmode:
  // 0 = always ready, 1 = toggling, 2 = random.
  task automatic run_txn(input bit wr, input logic [25:0] line, input logic [511:0] data,
                         input int ar_wait, input int rsp_wait, input int wmode, input bit rgaps);
    int  n, rbeat, bcnt;
    bit  done, leaving, wtog;
    o_data = 'x; o_write = 'x; o_addr = 'x; o_len = 'x; o_prot = 'x;
    o_latency = -1; o_arv = 0; o_awv = 0; o_wbeats = 0; o_wdata_err = 0; o_wlast_err = 0;
    o_rsp_cycles = 0; o_rsp_unstable = 0; o_rr_in_rsp = 0; o_extra = 0;
    o_ready_after = 'x; o_valid_after = 'x;
    rbeat = 0; bcnt = 0; done = 0; leaving = 0; wtog = 1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_write = wr; req_line = line; req_data = wr ? data : ~data;
    @(negedge clk);
    req_valid = 0; req_write = ~wr; req_line = ~line; req_data = rand_line();
    for (n = 1; n <= 400 && !done; n++) begin
      s_arready = 0; s_awready = 0; s_rvalid = 0; s_wready = 0; s_bvalid = 0; rsp_ready = 0;
      if (leaving) begin
        o_ready_after = req_ready; o_valid_after = rsp_valid; done = 1;
      end else begin
        if (m_arvalid) begin
          o_arv++; o_addr = m_aradr; o_len = m_arlen; o_prot = m_arprot;
          s_arready = (o_arv > ar_wait);
        end
        if (m_awvalid) begin
          o_awv++; o_addr = m_awadr; o_len = m_awlen; o_prot = m_awprot;
          s_awready = (o_awv > ar_wait);
        end
        if (m_rready && rbeat < 16) begin
          s_rvalid = rgaps ? ($urandom_range(0, 1) == 1) : 1'b1;
          if (s_rvalid) begin s_rdata = data[rbeat*32 +: 32]; rbeat++; end
        end
        if (m_wvalid) begin
          s_wready = (wmode == 0) ? 1'b1 : (wmode == 1) ? wtog : ($urandom_range(0, 1) == 1);
          wtog = ~wtog;
          if (s_wready) begin
            if (o_wbeats > 15 || m_wdata !== data[o_wbeats*32 +: 32]) o_wdata_err++;
            if (m_wlast !== (o_wbeats == 15)) o_wlast_err++;
            o_wbeats++;
          end
        end
        if (m_bready) begin bcnt++; s_bvalid = (bcnt > 2); end
        if (rsp_valid) begin
          o_rsp_cycles++;
          if (o_rsp_cycles == 1) begin
            o_latency = n; o_data = rsp_data; o_write = rsp_write;
          end else if (rsp_data !== o_data || rsp_write !== o_write) begin
            o_rsp_unstable++;
          end
          if (req_ready) o_rr_in_rsp++;
          if (o_rsp_cycles > rsp_wait) begin rsp_ready = 1; leaving = 1; end
        end
      end
      if (!done) @(negedge clk);
    end
    o_timeout = !done;
    repeat (3) begin @(negedge clk); if (rsp_valid) o_extra++; end
  endtask

  task automatic wide_txn(input bit wr, input logic [25:0] line, input logic [511:0] data);
    int n, b;
    bit done;
    wo_data = 'x; wo_write = 'x; wo_len = 'x; wo_latency = -1; wo_beats = 0; wo_err = 0;
    b = 0; done = 0; n = 0;
    while (w_req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    w_req_valid = 1; w_req_write = wr; w_req_line = line; w_req_data = wr ? data : ~data;
    @(negedge clk);
    w_req_valid = 0; w_req_data = rand_line();
    for (n = 1; n <= 200 && !done; n++) begin
      w_s_arready = w_m_arvalid; w_s_awready = w_m_awvalid;
      if (w_m_arvalid) wo_len = w_m_arlen;
      if (w_m_awvalid) wo_len = w_m_awlen;
      w_s_rvalid = w_m_rready && b < 4;
      if (w_s_rvalid) begin w_s_rdata = data[b*128 +: 128]; b++; end
      w_s_wready = w_m_wvalid;
      if (w_m_wvalid) begin
        if (wo_beats > 3 || w_m_wdata !== data[wo_beats*128 +: 128] || w_m_wlast !== (wo_beats == 3))
          wo_err++;
        wo_beats++;
      end
      w_s_bvalid = w_m_bready;
      w_rsp_ready = w_rsp_valid;
      if (w_rsp_valid) begin
        wo_latency = n; wo_data = w_rsp_data; wo_write = w_rsp_write; done = 1;
      end
      @(negedge clk);
    end
    wo_timeout = !done;
    w_s_arready = 0; w_s_awready = 0; w_s_rvalid = 0; w_s_wready = 0; w_s_bvalid = 0; w_rsp_ready = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    reset_n = 0;
    idle_inputs();
    repeat (3) @(negedge clk);
    flags = {req_ready, rsp_valid, m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready};
    tests_run++;
    if (flags !== 8'h00) begin
      tests_failed++; $display("FAIL reset_flags: got %b expected 00000000", flags);
    end
    tests_run++;
    if (rsp_data !== '0 || m_wdata !== '0 || m_aradr !== '0 || m_awadr !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: rsp_data=%h m_wdata=%h m_aradr=%h m_awadr=%h expected all 0",
               rsp_data, m_wdata, m_aradr, m_awadr);
    end
    reset_n = 1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_fill_basic();
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = k;
    run_txn(0, 26'h0000010, d, 0, 0, 0, 0);
    tests_run++;
    if (o_addr !== 32'h400 || o_len !== 8'd15 || o_prot !== 3'b000 || o_arv !== 1) begin
      tests_failed++;
      $display("FAIL fill_ar: addr=%h len=%0d prot=%b arvalid_cycles=%0d expected 400/15/000/1",
               o_addr, o_len, o_prot, o_arv);
    end
    tests_run++;
    if (o_data !== d || o_write !== 1'b0) begin
      tests_failed++; $display("FAIL fill_data: got %h write=%b expected %h write=0", o_data, o_write, d);
    end
    tests_run++;
    if (o_latency !== 18 || o_timeout) begin
      tests_failed++; $display("FAIL fill_latency: got %0d timeout=%b expected 18", o_latency, o_timeout);
    end
    tests_run++;
    if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0 || o_rr_in_rsp !== 0) begin
      tests_failed++;
      $display("FAIL fill_return_idle: ready_after=%b valid_after=%b ready_in_rsp=%0d expected 1/0/0",
               o_ready_after, o_valid_after, o_rr_in_rsp);
    end
  endtask

  task automatic test_writeback();
    logic [511:0] d;
    logic [25:0]  line;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'hA000_0000 + k;
    line = 26'($urandom);
    run_txn(1, line, d, 0, 0, 1, 0);
    tests_run++;
    if (o_addr !== {line, 6'b0} || o_len !== 8'd15 || o_prot !== 3'b000 || o_awv !== 1) begin
      tests_failed++;
      $display("FAIL wb_aw: addr=%h len=%0d prot=%b awvalid_cycles=%0d expected %h/15/000/1",
               o_addr, o_len, o_prot, o_awv, {line, 6'b0});
    end
    tests_run++;
    if (o_wbeats !== 16 || o_wdata_err !== 0) begin
      tests_failed++;
      $display("FAIL wb_beats: beats=%0d data_errors=%0d expected 16/0", o_wbeats, o_wdata_err);
    end
    tests_run++;
    if (o_wlast_err !== 0) begin
      tests_failed++; $display("FAIL wb_wlast: %0d misplaced wlast, expected 0", o_wlast_err);
    end
    tests_run++;
    if (o_write !== 1'b1 || o_data !== d || o_timeout) begin
      tests_failed++;
      $display("FAIL wb_rsp: write=%b data=%h timeout=%b expected write=1 data=%h", o_write, o_data, o_timeout, d);
    end
  endtask

  task automatic test_stalls();
    logic [511:0] d;
    d = rand_line();
    run_txn(0, 26'($urandom), d, 5, 3, 0, 1);
    tests_run++;
    if (o_arv !== 6) begin
      tests_failed++; $display("FAIL stall_arvalid: held %0d cycles expected 6", o_arv);
    end
    tests_run++;
    if (o_rsp_cycles !== 4 || o_rsp_unstable !== 0) begin
      tests_failed++;
      $display("FAIL stall_rsp_hold: cycles=%0d unstable=%0d expected 4/0", o_rsp_cycles, o_rsp_unstable);
    end
    tests_run++;
    if (o_extra !== 0 || o_data !== d) begin
      tests_failed++; $display("FAIL stall_single_rsp: extra=%0d data=%h expected 0/%h", o_extra, o_data, d);
    end
  endtask

  task automatic test_spurious();
    logic [511:0] d;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 1; s_rdata = $urandom; s_bvalid = 1; s_arready = 1; s_awready = 1; s_wready = 1;
      @(negedge clk);
      if (req_ready !== 1'b1 || {rsp_valid, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready} !== 6'b0)
        bad++;
    end
    s_rvalid = 0; s_bvalid = 0; s_arready = 0; s_awready = 0; s_wready = 0;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++; $display("FAIL spurious_idle: %0d disturbed cycles expected 0", bad);
    end
    d = rand_line();
    run_txn(0, 26'($urandom), d, 0, 0, 0, 0);
    tests_run++;
    if (o_data !== d || o_latency !== 18) begin
      tests_failed++;
      $display("FAIL spurious_fill: data=%h latency=%0d expected %h/18", o_data, o_latency, d);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d;
    int rbeat, n;
    d = rand_line();
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_write = 0; req_line = 26'($urandom); req_data = rand_line();
    @(negedge clk);
    req_valid = 0;
    rbeat = 0; n = 0;
    while (rbeat < 8 && n < 100) begin
      s_arready = m_arvalid; s_rvalid = 0;
      if (m_rready) begin s_rvalid = 1; s_rdata = d[rbeat*32 +: 32]; rbeat++; end
      @(negedge clk);
      n++;
    end
    s_arready = 0; s_rvalid = 0;
    reset_n = 0;
    @(negedge clk);
    tests_run++;
    if ({req_ready, rsp_valid, m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready} !== 8'h00 ||
        rbeat !== 8) begin
      tests_failed++;
      $display("FAIL reset_mid_flags: got %b after %0d beats expected 00000000 after 8",
               {req_ready, rsp_valid, m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready}, rbeat);
    end
    reset_n = 1;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_mid_ready: got %b expected 1", req_ready);
    end
    d = rand_line();
    run_txn(0, 26'($urandom), d, 0, 0, 0, 0);
    tests_run++;
    if (o_data !== d || o_latency !== 18) begin
      tests_failed++;
      $display("FAIL reset_mid_refill: data=%h latency=%0d expected %h/18", o_data, o_latency, d);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [511:0] d;
    logic [25:0]  line;
    bit           wr;
    for (int i = 0; i < 8; i++) begin
      d = rand_line(); line = 26'($urandom); wr = $urandom_range(0, 1) == 1;
      run_txn(wr, line, d, $urandom_range(0, 3), $urandom_range(0, 2), 2, 1);
      tests_run++;
      if (o_data !== d || o_write !== wr || o_addr !== {line, 6'b0} || o_len !== 8'd15 || o_timeout) begin
        tests_failed++;
        $display("FAIL random_%0d_rsp: data=%h write=%b addr=%h len=%0d timeout=%b expected %h/%b/%h/15",
                 i, o_data, o_write, o_addr, o_len, o_timeout, d, wr, {line, 6'b0});
      end
      tests_run++;
      if ((wr && (o_wbeats !== 16 || o_wdata_err !== 0 || o_wlast_err !== 0)) || (!wr && o_wbeats !== 0)) begin
        tests_failed++;
        $display("FAIL random_%0d_wbeats: beats=%0d data_err=%0d wlast_err=%0d write=%b",
                 i, o_wbeats, o_wdata_err, o_wlast_err, wr);
      end
      tests_run++;
      if (o_ready_after !== 1'b1 || o_valid_after !== 1'b0 || o_rr_in_rsp !== 0 || o_extra !== 0) begin
        tests_failed++;
        $display("FAIL random_%0d_spacing: ready_after=%b valid_after=%b ready_in_rsp=%0d extra=%0d expected 1/0/0/0",
                 i, o_ready_after, o_valid_after, o_rr_in_rsp, o_extra);
      end
    end
  endtask

  task automatic test_wide();
    logic [511:0] d;
    d = rand_line();
    wide_txn(0, 26'($urandom), d);
    tests_run++;
    if (wo_len !== 8'd3 || wo_data !== d || wo_write !== 1'b0 || wo_latency !== 6 || wo_timeout) begin
      tests_failed++;
      $display("FAIL wide_fill: len=%0d data=%h write=%b latency=%0d expected 3/%h/0/6", wo_len, wo_data,
               wo_write, wo_latency, d);
    end
    d = rand_line();
    wide_txn(1, 26'($urandom), d);
    tests_run++;
    if (wo_len !== 8'd3 || wo_beats !== 4 || wo_err !== 0 || wo_write !== 1'b1 || wo_data !== d || wo_timeout) begin
      tests_failed++;
      $display("FAIL wide_wb: len=%0d beats=%0d errors=%0d write=%b expected 3/4/0/1", wo_len, wo_beats,
               wo_err, wo_write);
    end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_writeback();
    test_stalls();
    test_spurious();
    test_reset_mid();
    test_random_back_to_back();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
